sar_adc_ctrl: RTL and testbench

Successive-approximation ADC controller: the code-generating counterpart of the flash-ADC thermometer decoder. It drives a binary trial code and its thermometer expansion to the reference DAC/resistor ladder, then samples a single comparator once per bit. It resolves an N-bit result MSB-first and presents it with a one-cycle done pulse. It sits between the analog front end (DAC + comparator) and the digital sample consumer.

---
 rtl/sar_adc_pkg.sv | 12 +
 rtl/bin2therm.sv | 18 +
 rtl/sar_adc_ctrl.sv | 109 ++++++++++
 tb/tb_sar_adc_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and widths for the successive-approximation ADC controller.
package sar_adc_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bin2therm.sv
// Binary to thermometer expander: bit k of therm_o is set iff bin_i > k.
module bin2therm #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        bin_i,
    output logic [(1<<N)-2:0]   therm_o
);

    localparam int unsigned THERM_W = (1 << N) - 1;

    always_comb begin
        therm_o = '0;
        for (int unsigned k = 0; k < THERM_W; k++) begin
            therm_o[k] = (32'(bin_i) > k);
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: resolves an N-bit code MSB-first against a single
// comparator, waiting SETTLE cycles after each trial code change.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                comp,
    output logic [N-1:0]        dac_code,
    output logic [(1<<N)-2:0]   dac_therm,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        result
);

    localparam int unsigned BIDX_W = (N > 1) ? $clog2(N) : 1;

    state_e              state_q, state_d;
    logic [N-1:0]        code_q, code_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N-1:0]        result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            code_q   <= '0;
            bidx_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            bidx_q   <= bidx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        bidx_d   = bidx_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                code_d = '0;
                if (start) begin
                    code_d[N-1] = 1'b1;
                    bidx_d      = BIDX_W'(N - 1);
                    cnt_d       = CNT_W'(SETTLE);
                    state_d     = TRIAL;
                end
            end
            TRIAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // comp high means the trial level overshoots Vin: drop the bit
                    if (comp) begin
                        code_d[bidx_q] = 1'b0;
                    end
                    if (bidx_q == '0) begin
                        result_d = code_d;
                        state_d  = DONE;
                    end else begin
                        code_d[bidx_q - BIDX_W'(1)] = 1'b1;
                        bidx_d = bidx_q - BIDX_W'(1);
                        cnt_d  = CNT_W'(SETTLE);
                    end
                end
            end
            DONE: begin
                code_d  = '0;
                state_d = IDLE;
            end
            default: begin
                code_d  = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign dac_code = code_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

    bin2therm #(.N(N)) u_therm (
        .bin_i   (code_q),
        .therm_o (dac_therm)
    );

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: four lanes (SETTLE 0..3) against an arithmetic
// binary-search model, with directed literal checks and random stimulus.
module tb_sar_adc_ctrl;

    localparam int N  = 4;
    localparam int NL = 4;
    localparam int TW = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic          comp      [NL];
    logic [N-1:0]  dac_code  [NL];
    logic [TW-1:0] dac_therm [NL];
    logic          busy      [NL];
    logic          done      [NL];
    logic [N-1:0]  result    [NL];

    int vin      [NL];
    int p        [NL];
    int vin_cur  [NL];
    int last_res [NL];

    int n_tests = 0;
    int n_fail  = 0;

    int lat  [NL];
    int bcnt [NL];
    int dcnt [NL];
    int trials [4];
    int therm_final1;
    int therm_done0;
    int m_code, m_busy, m_done;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        sar_adc_ctrl #(.N(N), .SETTLE(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .comp      (comp[g]),
            .dac_code  (dac_code[g]),
            .dac_therm (dac_therm[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .result    (result[g])
        );
    end

    function automatic int conv(input int s);
        return N * (s + 1);
    endfunction

    // Trial code for MSB-first step j: upper j bits already resolved to vin, bit j set.
    function automatic int trial(input int v, input int j);
        int hi;
        hi = N - j;
        return ((v >> hi) << hi) | (1 << (N - 1 - j));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model: p = cycles since accepting start (0 = idle), DONE at conv+1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NL; g++) begin
                p[g] = 0;
                last_res[g] = 0;
            end
        end else begin
            for (int g = 0; g < NL; g++) begin
                if (p[g] == 0) begin
                    if (start) begin
                        p[g] = 1;
                        vin_cur[g] = vin[g];
                    end
                end else if (p[g] == conv(g) + 1) begin
                    p[g] = 0;
                end else begin
                    p[g]++;
                    if (p[g] == conv(g) + 1) last_res[g] = vin_cur[g];
                end
            end
        end
    end

    // Comparator: ideal in sampling cycles, random noise otherwise.
    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) begin
            if (p[g] >= 1 && p[g] <= conv(g) && (p[g] % (g + 1)) == 0)
                comp[g] = (vin_cur[g] < int'(dac_code[g]));
            else
                comp[g] = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) begin
            if (p[g] == 0) begin
                m_code = 0; m_busy = 0; m_done = 0;
            end else if (p[g] <= conv(g)) begin
                m_code = trial(vin_cur[g], (p[g] - 1) / (g + 1));
                m_busy = 1; m_done = 0;
            end else begin
                m_code = vin_cur[g]; m_busy = 1; m_done = 1;
            end
            check($sformatf("model_dac_code[%0d]", g), int'(dac_code[g]), m_code);
            check($sformatf("model_dac_therm[%0d]", g), int'(dac_therm[g]), (1 << m_code) - 1);
            check($sformatf("model_busy[%0d]", g), int'(busy[g]), m_busy);
            check($sformatf("model_done[%0d]", g), int'(done[g]), m_done);
            check($sformatf("model_result[%0d]", g), int'(result[g]), last_res[g]);
        end
    end

    task automatic convert_all(input int v);
        int edges;
        for (int g = 0; g < NL; g++) begin
            vin[g] = v; lat[g] = 0; bcnt[g] = 0; dcnt[g] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            for (int g = 0; g < NL; g++) begin
                if (busy[g]) bcnt[g]++;
                if (done[g]) begin
                    dcnt[g]++;
                    if (lat[g] == 0) lat[g] = edges;
                end
            end
            if (edges >= 2 && edges <= 8 && (edges % 2) == 0)
                trials[edges / 2 - 1] = int'(dac_code[1]);
            if (edges == 8) therm_final1 = int'(dac_therm[1]);
            if (edges == 5) therm_done0 = int'(dac_therm[0]);
            @(negedge clk);
            edges++;
        end
        for (int g = 0; g < NL; g++) begin
            check($sformatf("latency[%0d] vin=%0d", g, v), lat[g], conv(g) + 1);
            check($sformatf("busy_len[%0d] vin=%0d", g, v), bcnt[g], conv(g) + 1);
            check($sformatf("done_width[%0d] vin=%0d", g, v), dcnt[g], 1);
            check($sformatf("result[%0d] vin=%0d", g, v), int'(result[g]), v);
        end
    endtask

    initial begin
        int d1, d2, edges;
        for (int g = 0; g < NL; g++) vin[g] = 0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            check($sformatf("reset_dac_code[%0d]", g), int'(dac_code[g]), 0);
            check($sformatf("reset_busy[%0d]", g), int'(busy[g]), 0);
            check($sformatf("reset_result[%0d]", g), int'(result[g]), 0);
        end
        rst = 1'b0;

        convert_all(11);
        check("trial0_vin11", trials[0], 8);
        check("trial1_vin11", trials[1], 12);
        check("trial2_vin11", trials[2], 10);
        check("trial3_vin11", trials[3], 11);
        check("therm_final_trial_vin11", therm_final1, 32'h07FF);
        check("lane1_latency_vin11", lat[1], 9);
        check("lane1_busy_len_vin11", bcnt[1], 9);

        convert_all(0);
        check("lane0_latency_vin0", lat[0], 5);
        check("lane0_result_vin0", int'(result[0]), 0);
        convert_all(15);
        check("lane0_therm_done_vin15", therm_done0, 32'h7FFF);
        check("lane0_result_vin15", int'(result[0]), 15);

        for (int v = 0; v < 16; v++) convert_all(v);

        // start held high: repeated conversions at the minimum spacing
        for (int g = 0; g < NL; g++) vin[g] = 9;
        @(negedge clk);
        start = 1'b1;
        d1 = -1; d2 = -1; edges = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            edges++;
            if (done[1]) begin
                if (d1 < 0) d1 = edges;
                else if (d2 < 0) d2 = edges;
            end
            if (c % 7 == 0) for (int g = 0; g < NL; g++) vin[g] = $urandom_range(0, 15);
        end
        check("held_start_spacing_lane1", d2 - d1, 10);
        start = 1'b0;
        repeat (24) @(negedge clk);

        // random starts (including during TRIAL/DONE) and random vin
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            for (int g = 0; g < NL; g++) vin[g] = $urandom_range(0, 15);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);

        // asynchronous reset mid-conversion after a result of 11
        convert_all(11);
        for (int g = 0; g < NL; g++) vin[g] = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            check($sformatf("mid_conv_busy[%0d]", g), int'(busy[g]), 1);
            check($sformatf("mid_conv_result_held[%0d]", g), int'(result[g]), 11);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int g = 0; g < NL; g++) begin
            check($sformatf("async_rst_dac_code[%0d]", g), int'(dac_code[g]), 0);
            check($sformatf("async_rst_therm[%0d]", g), int'(dac_therm[g]), 0);
            check($sformatf("async_rst_busy[%0d]", g), int'(busy[g]), 0);
            check($sformatf("async_rst_done[%0d]", g), int'(done[g]), 0);
            check($sformatf("async_rst_result[%0d]", g), int'(result[g]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        convert_all(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
